// File: rtl/leading_count_iter.sv
// leading_count_iter
//   Iterative leading/trailing zero/one counter. A request word is
//   conditioned once at acceptance: inverted when counting ones, and
//   bit-reversed when counting from the LSB. After that the scan always
//   counts leading zeros, one CHUNK_WIDTH slice per clock, MSB slice first.
//
// Parameters
//   DATA_WIDTH   width of the scanned word
//   CHUNK_WIDTH  bits examined per scan cycle (must divide DATA_WIDTH)
//   CNT_WIDTH    derived result width, $clog2(DATA_WIDTH+1)
//
// Ports
//   clk        clock
//   rst_n      synchronous active-low reset
//   in_valid   request valid          in_ready  block idle, can accept
//   in_data    word to scan           in_mode   [0]=count ones, [1]=trailing
//   out_valid  result valid           out_ready consumer accepts result
//   out_cnt    count result           out_all   no terminating bit found

// Leading-zero count inside a single chunk. Only meaningful for a nonzero
// chunk; the highest set bit wins, so the result is 0..W-1.
module lci_chunk_lz #(
  parameter  int W    = 8,
  localparam int LZ_W = $clog2(W + 1)
) (
  input  logic [W-1:0]    chunk,
  output logic [LZ_W-1:0] lz
);

  always_comb begin
    lz = '0;
    for (int i = 0; i < W; i++) begin
      if (chunk[i]) lz = LZ_W'(W - 1 - i);
    end
  end

endmodule

module leading_count_iter #(
  parameter  int DATA_WIDTH  = 32,
  parameter  int CHUNK_WIDTH = 8,
  localparam int CNT_WIDTH   = $clog2(DATA_WIDTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic [1:0]            in_mode,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [CNT_WIDTH-1:0]  out_cnt,
  output logic                  out_all
);

  localparam int NCHUNK = DATA_WIDTH / CHUNK_WIDTH;
  localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam int LZ_W   = $clog2(CHUNK_WIDTH + 1);

  localparam logic [IDX_W-1:0]     LAST_IDX   = IDX_W'(NCHUNK - 1);
  localparam logic [CNT_WIDTH-1:0] CHUNK_STEP = CNT_WIDTH'(CHUNK_WIDTH);
  localparam logic [CNT_WIDTH-1:0] FULL_CNT   = CNT_WIDTH'(DATA_WIDTH);

  if ((DATA_WIDTH % CHUNK_WIDTH) != 0 || CHUNK_WIDTH < 1) begin : g_bad_cfg
    $error("DATA_WIDTH must be a positive multiple of CHUNK_WIDTH");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SCAN = 2'd1,
    S_DONE = 2'd2
  } state_e;

  typedef struct packed {
    logic [CNT_WIDTH-1:0] cnt;
    logic                 all;
  } result_t;

  state_e                 state_q, state_d;
  logic [DATA_WIDTH-1:0]  work_q,  work_d;
  logic [CNT_WIDTH-1:0]   acc_q,   acc_d;
  logic [IDX_W-1:0]       idx_q,   idx_d;
  result_t                res_q,   res_d;

  // ---------------------------------------------------------------------
  // Request conditioning: fold the mode into the data so the scanner only
  // ever has to find the first 1 from the MSB side.
  // ---------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] in_inv;
  logic [DATA_WIDTH-1:0] in_rev;
  logic [DATA_WIDTH-1:0] in_work;

  assign in_inv = in_mode[0] ? ~in_data : in_data;

  for (genvar b = 0; b < DATA_WIDTH; b++) begin : g_rev
    assign in_rev[b] = in_inv[DATA_WIDTH-1-b];
  end

  assign in_work = in_mode[1] ? in_rev : in_inv;

  // ---------------------------------------------------------------------
  // Scanner datapath. The work word is shifted left one chunk per empty
  // chunk, so the chunk at index idx always sits in the top slice.
  // ---------------------------------------------------------------------
  logic [CHUNK_WIDTH-1:0] cur_chunk;
  logic [DATA_WIDTH-1:0]  work_shl;
  logic [LZ_W-1:0]        chunk_lz;
  logic                   chunk_hit;

  assign cur_chunk = work_q[DATA_WIDTH-1 -: CHUNK_WIDTH];
  assign chunk_hit = |cur_chunk;

  if (NCHUNK > 1) begin : g_shift
    assign work_shl = {work_q[DATA_WIDTH-CHUNK_WIDTH-1:0], {CHUNK_WIDTH{1'b0}}};
  end else begin : g_noshift
    // A single chunk is never shifted; the scan ends on its first cycle.
    assign work_shl = '0;
  end

  lci_chunk_lz #(
    .W (CHUNK_WIDTH)
  ) u_chunk_lz (
    .chunk (cur_chunk),
    .lz    (chunk_lz)
  );

  // ---------------------------------------------------------------------
  // FSM next-state and datapath updates
  // ---------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    work_d  = work_q;
    acc_d   = acc_q;
    idx_d   = idx_q;
    res_d   = res_q;

    unique case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          work_d  = in_work;
          acc_d   = '0;
          idx_d   = '0;
          state_d = S_SCAN;
        end
      end

      S_SCAN: begin
        if (chunk_hit) begin
          // acc <= DATA_WIDTH-CHUNK_WIDTH and lz <= CHUNK_WIDTH-1, so the
          // sum stays below DATA_WIDTH and cannot wrap.
          res_d.cnt = acc_q + CNT_WIDTH'(chunk_lz);
          res_d.all = 1'b0;
          state_d   = S_DONE;
        end else if (idx_q == LAST_IDX) begin
          res_d.cnt = FULL_CNT;
          res_d.all = 1'b1;
          state_d   = S_DONE;
        end else begin
          acc_d  = acc_q + CHUNK_STEP;
          idx_d  = idx_q + IDX_W'(1);
          work_d = work_shl;
        end
      end

      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      work_q  <= '0;
      acc_q   <= '0;
      idx_q   <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
      acc_q   <= acc_d;
      idx_q   <= idx_d;
      res_q   <= res_d;
    end
  end

  // The result register is only written on entry to DONE, so the last
  // answer stays visible through IDLE and the next SCAN.
  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign out_cnt   = res_q.cnt;
  assign out_all   = res_q.all;

endmodule

// File: tb/tb_leading_count_iter.sv
// Bench for leading_count_iter: four instances (CHUNK_WIDTH 1, 4, 8, 32)
// run the same directed vectors and a randomized phase. The driver pushes
// expected results into a per-instance queue; one monitor process pops and
// compares on each output handshake, and also checks latency, hold-under-
// stall, post-handshake ready and reset state.
module tb_leading_count_iter;

  localparam int DW   = 32;
  localparam int CNTW = 6;
  localparam int NI   = 4;
  localparam int CWS [NI] = '{1, 4, 8, 32};

  typedef struct {
    int cnt;
    bit all;
    int due;
  } exp_t;

  logic            clk;
  int              cyc;
  logic            rst_n_a     [NI];
  logic            in_valid_a  [NI];
  logic            in_ready_a  [NI];
  logic [DW-1:0]   in_data_a   [NI];
  logic [1:0]      in_mode_a   [NI];
  logic            out_valid_a [NI];
  logic            out_ready_a [NI];
  logic [CNTW-1:0] out_cnt_a   [NI];
  logic            out_all_a   [NI];

  int   rdy_mode [NI];   // 0: hold low, 1: hold high, 2: random stalls
  exp_t sb [NI][$];

  int n_cmp, n_bad;
  bit rst_seen [NI], vseen [NI], have_last [NI];
  int last_cnt [NI];
  bit last_all [NI];

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    leading_count_iter #(
      .DATA_WIDTH  (DW),
      .CHUNK_WIDTH (CWS[g])
    ) u_dut (
      .clk       (clk),
      .rst_n     (rst_n_a[g]),
      .in_valid  (in_valid_a[g]),
      .in_ready  (in_ready_a[g]),
      .in_data   (in_data_a[g]),
      .in_mode   (in_mode_a[g]),
      .out_valid (out_valid_a[g]),
      .out_ready (out_ready_a[g]),
      .out_cnt   (out_cnt_a[g]),
      .out_all   (out_all_a[g])
    );
  end

  // Reference: walk the bits in scan order and stop at the first bit that
  // differs from the value being counted.
  function automatic int ref_cnt(input logic [31:0] d, input logic [1:0] m);
    for (int i = 0; i < 32; i++) begin
      int pos;
      pos = m[1] ? i : 31 - i;
      if (d[pos] != m[0]) return i;
    end
    return 32;
  endfunction

  task automatic chk(input string nm, input int i, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s cw=%0d cycle=%0d got=%0d expected=%0d", nm, CWS[i], cyc, act, exp);
    end
  endtask

  // ---------------------------------------------------------------------
  // Monitor
  // ---------------------------------------------------------------------
  always @(negedge clk) begin
    for (int i = 0; i < NI; i++) begin
      exp_t e;
      if (rst_seen[i]) begin
        chk("rst_in_ready",  i, int'(in_ready_a[i]),  1);
        chk("rst_out_valid", i, int'(out_valid_a[i]), 0);
        chk("rst_out_cnt",   i, int'(out_cnt_a[i]),   0);
        chk("rst_out_all",   i, int'(out_all_a[i]),   0);
        vseen[i]     = 1'b0;
        have_last[i] = 1'b0;
      end else if (out_valid_a[i]) begin
        chk("sb_depth", i, sb[i].size(), 1);
        if (sb[i].size() != 0) begin
          e = sb[i][0];
          if (!vseen[i]) chk("latency", i, cyc, e.due);
          chk("out_cnt",       i, int'(out_cnt_a[i]),  e.cnt);
          chk("out_all",       i, int'(out_all_a[i]),  int'(e.all));
          chk("in_ready_busy", i, int'(in_ready_a[i]), 0);
          if (out_ready_a[i]) begin
            e            = sb[i].pop_front();
            last_cnt[i]  = e.cnt;
            last_all[i]  = e.all;
            have_last[i] = 1'b1;
          end
        end
        vseen[i] = 1'b1;
      end else begin
        if (have_last[i]) begin
          chk("hold_cnt", i, int'(out_cnt_a[i]), last_cnt[i]);
          chk("hold_all", i, int'(out_all_a[i]), int'(last_all[i]));
        end
        // the cycle right after a handshake must be idle again
        if (vseen[i]) chk("in_ready_after_hs", i, int'(in_ready_a[i]), 1);
        vseen[i] = 1'b0;
      end
      rst_seen[i] = !rst_n_a[i];
    end
  end

  // ---------------------------------------------------------------------
  // out_ready generator
  // ---------------------------------------------------------------------
  initial begin
    for (int i = 0; i < NI; i++) out_ready_a[i] = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      for (int i = 0; i < NI; i++) begin
        case (rdy_mode[i])
          0:       out_ready_a[i] = 1'b0;
          1:       out_ready_a[i] = 1'b1;
          default: out_ready_a[i] = ($urandom_range(0, 3) != 0);
        endcase
      end
    end
  end

  // ---------------------------------------------------------------------
  // Driver
  // ---------------------------------------------------------------------
  task automatic send(input int i, input logic [31:0] d, input logic [1:0] m, input int cnt);
    int   n, k;
    exp_t e;
    n = 0;
    @(posedge clk);
    #1;
    in_valid_a[i] = 1'b1;
    in_data_a[i]  = d;
    in_mode_a[i]  = m;
    @(negedge clk);
    while (!in_ready_a[i]) begin
      n++;
      if (n > 300) begin
        $display("FAIL accept_timeout cw=%0d cycle=%0d", CWS[i], cyc);
        $fatal(1);
      end
      @(negedge clk);
    end
    k = cnt / CWS[i];
    if (k > DW / CWS[i] - 1) k = DW / CWS[i] - 1;
    e.cnt = cnt;
    e.all = (cnt == DW);
    e.due = cyc + k + 2;
    sb[i].push_back(e);
    @(posedge clk);
    #1;
    // scramble inputs after acceptance; they must not affect the result
    in_valid_a[i] = 1'b0;
    in_data_a[i]  = $urandom;
    in_mode_a[i]  = 2'($urandom_range(0, 3));
  endtask

  task automatic drain(input int i);
    int n;
    n = 0;
    while (sb[i].size() != 0) begin
      @(negedge clk);
      n++;
      if (n > 500) begin
        $display("FAIL drain_timeout cw=%0d cycle=%0d", CWS[i], cyc);
        $fatal(1);
      end
    end
    @(negedge clk);
  endtask

  initial begin
    logic [31:0] d;
    logic [1:0]  m;
    int          sh, n;
    exp_t        dropped;

    n_cmp = 0;
    n_bad = 0;
    for (int i = 0; i < NI; i++) begin
      rst_n_a[i]    = 1'b0;
      in_valid_a[i] = 1'b0;
      in_data_a[i]  = '0;
      in_mode_a[i]  = 2'b00;
      rdy_mode[i]   = 1;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < NI; i++) rst_n_a[i] = 1'b1;

    for (int i = 0; i < NI; i++) begin
      // directed vectors
      send(i, 32'h0001_0000, 2'b00, 15); drain(i);
      send(i, 32'h0000_0000, 2'b00, 32); drain(i);
      send(i, 32'h0000_0100, 2'b10,  8); drain(i);
      send(i, 32'hFFF0_0000, 2'b01, 12); drain(i);
      send(i, 32'h8000_0000, 2'b00,  0); drain(i);
      send(i, 32'h0000_0001, 2'b00, 31); drain(i);
      send(i, 32'hFFFF_FFFF, 2'b11, 32); drain(i);
      send(i, 32'h7FFF_FFFF, 2'b11, 31); drain(i);

      // backpressure: hold out_ready low while DONE
      rdy_mode[i] = 0;
      send(i, 32'h00F0_0000, 2'b00, 8);
      n = 0;
      while (!out_valid_a[i]) begin
        @(negedge clk);
        n++;
        if (n > 100) begin
          $display("FAIL out_valid_timeout cw=%0d cycle=%0d", CWS[i], cyc);
          $fatal(1);
        end
      end
      repeat (4) @(negedge clk);
      @(posedge clk);
      #1;
      rdy_mode[i] = 1;
      drain(i);
      send(i, 32'h0000_0F00, 2'b10, 8); drain(i);

      // reset during SCAN, with in_valid held high across the reset edge
      send(i, 32'h0000_0000, 2'b00, 32);
      rst_n_a[i]    = 1'b0;
      in_valid_a[i] = 1'b1;
      in_data_a[i]  = 32'h0000_FFFF;
      dropped       = sb[i].pop_back();
      @(posedge clk);
      #1;
      rst_n_a[i]    = 1'b1;
      in_valid_a[i] = 1'b0;
      send(i, 32'h0003_0000, 2'b00, 14); drain(i);

      // randomized phase with random out_ready stalls
      rdy_mode[i] = 2;
      repeat (40) begin
        m  = 2'($urandom_range(0, 3));
        d  = $urandom;
        sh = $urandom_range(0, 32);
        if (sh == 32) d = '0;
        else d = m[1] ? (d << sh) : (d >> sh);
        if (m[0]) d = ~d;
        send(i, d, m, ref_cnt(d, m));
        repeat ($urandom_range(0, 2)) @(posedge clk);
      end
      drain(i);
      rdy_mode[i] = 1;
    end

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
